mem_bus_controller: RTL and testbench

- Synchronous front-end that sits directly upstream of the team's 64x64 asynchronous memory array.
- Converts a clocked request/ready client interface into the array's level-sensitive MemWrite/MemRead/Addr strobes.
- Owns the bidirectional 64-bit DataBus: drives it only during writes and tristates it otherwise.
- Sequences setup, strobe and hold phases so the array's combinational write never sees a changing address or data while MemWrite is high.

---
 rtl/mem_bus_controller.sv | 112 +++++++++++
 tb/tb_mem_bus_controller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_controller.sv
//==============================================================================
// Module      : mem_bus_controller
// Description : Clocked request/ready front-end for a 64x64 asynchronous
//               memory array. It sequences setup/strobe/hold phases for
//               writes and a stretched read strobe with data capture.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_bus_controller #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 64,
    parameter int RD_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              wdone,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              MemWrite,
    output logic              MemRead,
    output logic [ADDR_W-1:0] Addr,
    inout  wire  [DATA_W-1:0] DataBus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_SETUP  = 3'd1,
        WR_STROBE = 3'd2,
        WR_HOLD   = 3'd3,
        RD_STROBE = 3'd4,
        RD_DONE   = 3'd5
    } state_t;

    localparam logic [3:0] C_RD_WAIT = 4'(RD_WAIT);

    state_t              r_state;
    state_t              w_state_n;
    logic [3:0]          r_cnt;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_drive;
    logic                w_accept;
    logic                w_capture;

    assign w_accept  = (r_state == IDLE) && req;
    assign w_capture = (r_state == RD_STROBE) && (r_cnt == C_RD_WAIT);

    // The bus is only driven while a write is being set up, strobed or held.
    assign DataBus = r_drive ? r_wdata : {DATA_W{1'bz}};

    // Next-state logic for the write/read sequencer.
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE:      if (req) w_state_n = we ? WR_SETUP : RD_STROBE;
            WR_SETUP:  w_state_n = WR_STROBE;
            WR_STROBE: w_state_n = WR_HOLD;
            WR_HOLD:   w_state_n = IDLE;
            RD_STROBE: if (w_capture) w_state_n = RD_DONE;
            RD_DONE:   w_state_n = IDLE;
            default:   w_state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_n;
    end

    // Outputs are decoded from the next state and registered, so every pin
    // changes on the same edge as the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready    <= 1'b1;
            wdone    <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            MemWrite <= 1'b0;
            MemRead  <= 1'b0;
            Addr     <= '0;
            r_cnt    <= '0;
            r_wdata  <= '0;
            r_drive  <= 1'b0;
        end else begin
            ready    <= (w_state_n == IDLE);
            wdone    <= (w_state_n == WR_HOLD);
            rvalid   <= (w_state_n == RD_DONE);
            MemWrite <= (w_state_n == WR_STROBE);
            MemRead  <= (w_state_n == RD_STROBE);
            r_drive  <= (w_state_n == WR_SETUP) || (w_state_n == WR_STROBE) ||
                        (w_state_n == WR_HOLD);
            if (w_accept) begin
                Addr    <= addr;
                r_wdata <= wdata;
                r_cnt   <= '0;
            end else if (r_state == RD_STROBE) begin
                r_cnt   <= r_cnt + 4'd1;
            end
            // Bus is sampled verbatim; the read strobe has been held long enough.
            if (w_capture) rdata <= DataBus;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_controller.sv
//==============================================================================
// Module      : tb_mem_bus_controller
// Description : Randomized scoreboard bench for mem_bus_controller with an
//               asynchronous memory array model on the shared data bus.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_bus_controller;

    localparam int RD_WAIT = 1;

    typedef struct packed {
        logic        is_wr;
        logic [63:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [5:0]  addr;
    logic [63:0] wdata;
    logic        ready;
    logic        wdone;
    logic        rvalid;
    logic [63:0] rdata;
    logic        MemWrite;
    logic        MemRead;
    logic [5:0]  Addr;
    wire  [63:0] bus;

    int          checks;
    int          errors;
    exp_t        sb[$];
    logic [63:0] ref_mem [64];
    logic [63:0] mem_arr [64];

    mem_bus_controller #(.ADDR_W(6), .DATA_W(64), .RD_WAIT(RD_WAIT)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .wdone(wdone), .rvalid(rvalid), .rdata(rdata),
        .MemWrite(MemWrite), .MemRead(MemRead), .Addr(Addr), .DataBus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous array: drives the bus while read-strobed, stores while write-strobed.
    assign bus = MemRead ? mem_arr[Addr] : 64'bz;
    always @(negedge clk) if (MemWrite) mem_arr[Addr] <= bus;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issue one transaction from a negedge and follow it until ready returns.
    task automatic do_txn(input logic w, input logic [5:0] a, input logic [63:0] d,
                          input bit poke);
        int cnt;
        int lat;
        exp_t e;
        cnt = 0;
        while (!ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (!ready) begin
            chk("ready_timeout", ready, 1'b1);
            return;
        end
        e.is_wr = w;
        if (w) begin
            ref_mem[a] = d;
            e.data = '0;
        end else begin
            e.data = ref_mem[a];
        end
        sb.push_back(e);
        req = 1'b1; we = w; addr = a; wdata = d;
        lat = w ? 4 : RD_WAIT + 3;
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            if (i == 1) req = 1'b0;
            if (poke && i == 2) begin
                req = 1'b1; we = 1'b1; addr = a ^ 6'h2A; wdata = ~d;
            end
            if (poke && i == 3) req = 1'b0;
            chk("ready_phase", ready, (i == lat));
            chk("memwrite_phase", MemWrite, (w && i == 2));
            chk("memread_phase", MemRead, (!w && i <= RD_WAIT + 1));
            if (i < lat) chk("addr_phase", Addr, a);
        end
    endtask

    // Monitor: pops the scoreboard on every response and watches bus invariants.
    initial begin
        exp_t        e;
        logic [63:0] last_rd;
        logic        prev_strobe;
        logic [5:0]  prev_addr;
        last_rd = '0; prev_strobe = 1'b0; prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_rd = '0;
                prev_strobe = 1'b0;
            end else begin
                chk("dual_strobe", MemWrite & MemRead, 1'b0);
                chk("dual_resp", wdone & rvalid, 1'b0);
                if ((MemWrite || MemRead) && prev_strobe) chk("addr_stable", Addr, prev_addr);
                prev_strobe = MemWrite || MemRead;
                prev_addr = Addr;
                if (wdone || rvalid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp actual wdone=%0b rvalid=%0b required none",
                                 wdone, rvalid);
                    end else begin
                        e = sb.pop_front();
                        chk("resp_kind", wdone, e.is_wr);
                        if (!e.is_wr) last_rd = e.data;
                        chk("rdata", rdata, last_rd);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", ready, 1'b1);
        chk("rst_wdone", wdone, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 64'h0);
        chk("rst_memwrite", MemWrite, 1'b0);
        chk("rst_memread", MemRead, 1'b0);
        chk("rst_addr", Addr, 6'h0);

        // Directed write / read-back and boundary addresses.
        do_txn(1'b1, 6'h05, 64'hDEADBEEF_CAFEF00D, 1'b0);
        do_txn(1'b0, 6'h05, 64'h0, 1'b0);
        do_txn(1'b1, 6'h00, 64'h1, 1'b0);
        do_txn(1'b1, 6'h3F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        do_txn(1'b0, 6'h00, 64'h0, 1'b0);
        do_txn(1'b0, 6'h3F, 64'h0, 1'b0);

        // Reset asserted for two cycles while the write strobe is high.
        req = 1'b1; we = 1'b1; addr = 6'h11; wdata = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("abort_strobe_seen", MemWrite, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_memwrite", MemWrite, 1'b0);
        chk("abort_ready", ready, 1'b1);
        chk("abort_rdata", rdata, 64'h0);
        chk("abort_wdone", wdone, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_rewrite", MemWrite, 1'b0);
        end

        // Request pulsed during the write strobe must be ignored.
        do_txn(1'b1, 6'h0A, 64'h0A0A_0A0A_0A0A_0A0A, 1'b0);
        do_txn(1'b1, 6'h20, 64'h2020_2020_2020_2020, 1'b1);
        do_txn(1'b0, 6'h0A, 64'h0, 1'b0);
        do_txn(1'b0, 6'h20, 64'h0, 1'b0);

        // Back-to-back fill and read-back of every location.
        for (int a = 0; a < 64; a++)
            do_txn(1'b1, 6'(a), 64'(a) * 64'h0101_0101_0101_0101, 1'b0);
        for (int a = 0; a < 64; a++)
            do_txn(1'b0, 6'(a), 64'h0, 1'b0);

        // Randomized mix against the reference memory.
        for (int n = 0; n < 150; n++) begin
            logic       rw;
            logic [5:0] ra;
            rw = 1'($urandom_range(0, 1));
            ra = 6'($urandom_range(0, 63));
            do_txn(rw, ra, {$urandom, $urandom}, rw && ($urandom_range(0, 7) == 0));
        end

        repeat (10) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
